// File: rtl/vga_sync_gen_pkg.sv
// Shared VGA raster definitions: default 640x480@60 timing, derived totals and
// the 10-bit coordinate type used by the sync generator and the block renderer.
package vga_pkg;

    localparam int unsigned COORD_W = 10;

    typedef logic [COORD_W-1:0] vga_coord_t;

    function automatic int unsigned span_total(input int unsigned active, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    localparam int unsigned DEF_H_ACTIVE    = 640;
    localparam int unsigned DEF_H_FP        = 16;
    localparam int unsigned DEF_H_SYNC      = 96;
    localparam int unsigned DEF_H_BP        = 48;
    localparam int unsigned DEF_V_ACTIVE    = 480;
    localparam int unsigned DEF_V_FP        = 10;
    localparam int unsigned DEF_V_SYNC      = 2;
    localparam int unsigned DEF_V_BP        = 33;
    localparam int unsigned DEF_CLK_DIV     = 4;
    localparam int unsigned DEF_DROP_FRAMES = 30;

    localparam int unsigned DEF_H_TOTAL = span_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int unsigned DEF_V_TOTAL = span_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_sync_gen_clk_en_div.sv
// Clock-enable divider: en is high for one clock out of every CLK_DIV, on the
// clock where the internal count sits at CLK_DIV-1.
module clk_en_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic en
);

    localparam int unsigned W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] DIV_LAST = W'(CLK_DIV - 1);

    logic [W-1:0] div_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + W'(1);
        end
    end

    assign en = (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator (counters, sync decode, pixel/frame strobes).
// Optional gravity tick every DROP_FRAMES frames when VGA_SYNC_DROP_TICK_EN is defined.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
    parameter int unsigned H_FP        = DEF_H_FP,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BP        = DEF_H_BP,
    parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
    parameter int unsigned V_FP        = DEF_V_FP,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BP        = DEF_V_BP,
`ifdef VGA_SYNC_DROP_TICK_EN
    parameter int unsigned DROP_FRAMES = DEF_DROP_FRAMES,
`endif
    parameter int unsigned CLK_DIV     = DEF_CLK_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] horizontal_position,
    output logic [9:0] vertical_position,
    output logic       pixel_tick,
    output logic       frame_start
`ifdef VGA_SYNC_DROP_TICK_EN
    ,
    output logic       drop_tick
`endif
);

    localparam int unsigned H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if ((H_TOTAL > 1024) || (V_TOTAL > 1024) || (CLK_DIV < 1)) begin : g_bad_params
        $error("vga_sync_gen: totals must be <= 1024 and CLK_DIV >= 1");
    end

    localparam vga_coord_t H_LAST   = vga_coord_t'(H_TOTAL - 1);
    localparam vga_coord_t V_LAST   = vga_coord_t'(V_TOTAL - 1);
    localparam vga_coord_t H_VIS    = vga_coord_t'(H_ACTIVE);
    localparam vga_coord_t V_VIS    = vga_coord_t'(V_ACTIVE);
    localparam vga_coord_t HS_FIRST = vga_coord_t'(H_ACTIVE + H_FP);
    localparam vga_coord_t HS_LAST  = vga_coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam vga_coord_t VS_FIRST = vga_coord_t'(V_ACTIVE + V_FP);
    localparam vga_coord_t VS_LAST  = vga_coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic       advance;
    vga_coord_t h_cnt, v_cnt;
    vga_coord_t h_next, v_next;
    logic       h_wrap, frame_wrap;

    clk_en_div #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_en_div (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (advance)
    );

    always_comb begin
        h_wrap     = (h_cnt == H_LAST);
        frame_wrap = h_wrap && (v_cnt == V_LAST);
        h_next     = h_wrap ? '0 : h_cnt + vga_coord_t'(1);
        v_next     = v_cnt;
        if (h_wrap) begin
            v_next = (v_cnt == V_LAST) ? '0 : v_cnt + vga_coord_t'(1);
        end
    end

    // Outputs decode the next-state counters so they line up with the positions
    // presented in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b1;
            pixel_tick  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pixel_tick  <= advance;
            frame_start <= advance && frame_wrap;
            if (advance) begin
                h_cnt    <= h_next;
                v_cnt    <= v_next;
                hsync    <= !((h_next >= HS_FIRST) && (h_next <= HS_LAST));
                vsync    <= !((v_next >= VS_FIRST) && (v_next <= VS_LAST));
                video_on <= (h_next < H_VIS) && (v_next < V_VIS);
            end
        end
    end

    assign horizontal_position = h_cnt;
    assign vertical_position   = v_cnt;

`ifdef VGA_SYNC_DROP_TICK_EN
    localparam int unsigned FW = (DROP_FRAMES > 1) ? $clog2(DROP_FRAMES) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(DROP_FRAMES - 1);

    logic [FW-1:0] frame_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            drop_tick <= 1'b0;
        end else begin
            drop_tick <= advance && frame_wrap && (frame_cnt == FRAME_LAST);
            if (advance && frame_wrap) begin
                frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + FW'(1);
            end
        end
    end
`endif

endmodule
